// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: single outstanding imem request,
// one-entry skid buffer for stalls, and squash-to-bubble handling of decode redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] jumpOrBranchPc,
  output logic        imem_request,
  output logic [31:0] imem_address,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] pc_4,
  output logic [31:0] instruction,
  output logic        instructionValid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] redir_pc;
  logic [31:0] buf_pc_4;
  logic [31:0] buf_instr;
  logic        redirect;
  logic [31:0] next_pc;

  // Stall outranks redirect: decode cannot act on a branch it is holding.
  assign redirect     = shouldJumpOrBranch && !shouldStall;
  assign next_pc      = fetch_pc + 32'd4;
  assign imem_request = (state == S_FETCH) || (state == S_DROP);
  assign imem_address = fetch_pc;

  // Fetch sequencer, skid buffer and IF/ID register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      fetch_pc         <= RESET_PC;
      redir_pc         <= 32'd0;
      buf_pc_4         <= 32'd0;
      buf_instr        <= NOP;
      pc_4             <= 32'd0;
      instruction      <= NOP;
      instructionValid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (redirect) begin
            instruction      <= NOP;
            instructionValid <= 1'b0;
            if (imem_ready) begin
              fetch_pc <= jumpOrBranchPc;
            end else begin
              redir_pc <= jumpOrBranchPc;
              state    <= S_DROP;
            end
          end else if (imem_ready) begin
            fetch_pc <= next_pc;
            if (!shouldStall) begin
              pc_4             <= next_pc;
              instruction      <= imem_data;
              instructionValid <= 1'b1;
            end else begin
              buf_pc_4  <= next_pc;
              buf_instr <= imem_data;
              state     <= S_WAIT;
            end
          end else if (!shouldStall) begin
            instruction      <= NOP;
            instructionValid <= 1'b0;
          end
        end
        S_DROP: begin
          // The old request cannot be withdrawn; wait it out and discard the word.
          if (!shouldStall) begin
            instruction      <= NOP;
            instructionValid <= 1'b0;
          end
          if (imem_ready) begin
            fetch_pc <= redir_pc;
            state    <= S_FETCH;
          end
        end
        S_WAIT: begin
          if (!shouldStall) begin
            if (shouldJumpOrBranch) begin
              instruction      <= NOP;
              instructionValid <= 1'b0;
              fetch_pc         <= jumpOrBranchPc;
            end else begin
              pc_4             <= buf_pc_4;
              instruction      <= buf_instr;
              instructionValid <= 1'b1;
            end
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage: the bench plays instruction memory and decode,
// predicting the in-order stream decode should consume from PC arithmetic and redirects.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        shouldStall;
  logic        shouldJumpOrBranch;
  logic [31:0] jumpOrBranchPc;
  logic        imem_request;
  logic [31:0] imem_address;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] pc_4;
  logic [31:0] instruction;
  logic        instructionValid;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int idle   = 0;

  logic [63:0] q[$];
  logic [31:0] exp_pc;
  logic        pend_valid;
  logic [31:0] pend_addr;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clock              (clock),
    .reset              (reset),
    .shouldStall        (shouldStall),
    .shouldJumpOrBranch (shouldJumpOrBranch),
    .jumpOrBranchPc     (jumpOrBranchPc),
    .imem_request       (imem_request),
    .imem_address       (imem_address),
    .imem_ready         (imem_ready),
    .imem_data          (imem_data),
    .pc_4               (pc_4),
    .instruction        (instruction),
    .instructionValid   (instructionValid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h2402_0005;
  endfunction

  assign imem_data = mem_word(imem_address);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic top_up();
    while (q.size() < 4) begin
      q.push_back({exp_pc + 32'd4, mem_word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req",   {31'd0, imem_request}, 32'd0);
    check("rst_addr",  imem_address, RESET_PC);
    check("rst_pc_4",  pc_4, 32'd0);
    check("rst_instr", instruction, NOP);
    check("rst_valid", {31'd0, instructionValid}, 32'd0);
  endtask

  // Monitor: consume IF/ID whenever decode takes a real instruction, plus handshake checks.
  always @(negedge clock) begin
    if (reset) begin
      pend_valid = 1'b0;
      idle = 0;
    end else begin
      if (instructionValid && !shouldStall) begin
        if (q.size() == 0) begin
          check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          logic [63:0] e;
          e = q.pop_front();
          check("ifid_pc_4", pc_4, e[63:32]);
          check("ifid_instr", instruction, e[31:0]);
          pops++;
        end
        idle = 0;
      end else begin
        idle++;
        if (idle == 300) check("progress_timeout", 32'd0, 32'd1);
      end
      if (!instructionValid) check("bubble_nop", instruction, NOP);
      if (pend_valid) begin
        check("req_held", {31'd0, imem_request}, 32'd1);
        check("addr_held", imem_address, pend_addr);
      end
      pend_valid = imem_request && !imem_ready;
      pend_addr  = imem_address;
    end
  end

  // Driver: memory readiness, decode stall/redirect, resets, and the reference model.
  initial begin
    logic [63:0] head;
    logic [31:0] tgt;
    reset = 1'b1;
    shouldStall = 1'b0;
    shouldJumpOrBranch = 1'b0;
    jumpOrBranchPc = 32'd0;
    imem_ready = 1'b1;
    pend_valid = 1'b0;
    pend_addr = 32'd0;
    exp_pc = RESET_PC;
    #2;
    check_reset_outputs();

    // Zero-wait memory: one fetch per cycle after the IDLE cycle.
    @(posedge clock); #1;
    reset = 1'b0;
    top_up();
    check("idle_no_req", {31'd0, imem_request}, 32'd0);
    @(posedge clock); #1;
    top_up();
    check("first_req", {31'd0, imem_request}, 32'd1);
    check("first_addr", imem_address, RESET_PC);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock); #1;
      top_up();
      check("zw_addr", imem_address, RESET_PC + 32'(4 * i));
      check("zw_pc_4", pc_4, RESET_PC + 32'(4 * i));
      check("zw_valid", {31'd0, instructionValid}, 32'd1);
    end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clock); #1;
      if (cyc % 700 == 350) begin
        reset = 1'b1;
        shouldStall = 1'b0;
        shouldJumpOrBranch = 1'b0;
        q.delete();
        exp_pc = RESET_PC;
        #1;
        check_reset_outputs();
        @(posedge clock); #1;
        reset = 1'b0;
        top_up();
        check("post_rst_idle", {31'd0, imem_request}, 32'd0);
        @(posedge clock); #1;
        top_up();
        check("post_rst_req", {31'd0, imem_request}, 32'd1);
        check("post_rst_addr", imem_address, RESET_PC);
      end else begin
        imem_ready = ((cyc / 200) % 4 == 1) ? 1'b1 : ($urandom_range(0, 9) < 6);
        shouldStall = ($urandom_range(0, 9) < 3);
        shouldJumpOrBranch = 1'b0;
        tgt = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_0FFC);
        jumpOrBranchPc = tgt;
        if (shouldStall) begin
          shouldJumpOrBranch = ($urandom_range(0, 3) == 0);
        end else if (instructionValid && $urandom_range(0, 7) == 0) begin
          // Decode branches on the instruction it holds; everything younger is wrong-path.
          shouldJumpOrBranch = 1'b1;
          if (q.size() > 0) begin
            head = q[0];
            q.delete();
            q.push_back(head);
          end
          exp_pc = tgt;
        end
        top_up();
      end
    end

    @(posedge clock); #1;
    shouldStall = 1'b0;
    shouldJumpOrBranch = 1'b0;
    check("consumed_enough", {31'd0, pops > 300}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
